// File: rtl/prince_round_ctrl_param.sv
//==============================================================================
// Module   : prince_round_ctrl_param
// Brief    : Round controller for masked PRINCE cores with start/busy/done
//            handshake, reduced-round and multi-cycle-per-round support.
// Revision : 1.0
//==============================================================================
`default_nettype none

module prince_round_ctrl_param #(
    parameter int NR_HALF  = 5,
    parameter int SBOX_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        clr_i,
    input  logic        enc_i,
    input  logic [63:0] k_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        load_o,
    output logic        step_o,
    output logic        mid_o,
    output logic [3:0]  rnd_o,
    output logic [3:0]  sub_o,
    output logic        fwd_o,
    output logic        inv_o,
    output logic [63:0] rc_o,
    output logic [63:0] rc2_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] C_NH       = 4'(NR_HALF);
    localparam logic [3:0] C_LAST     = 4'(2 * NR_HALF + 1);
    localparam logic [3:0] C_OFS      = 4'(10 - 2 * NR_HALF);
    localparam logic [3:0] C_SUB_LAST = 4'(SBOX_LAT - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic [3:0] sub_q, sub_d;
    logic       enc_q, enc_d;

    function automatic logic [63:0] rc_const(input logic [3:0] i);
        case (i)
            4'd1:    return 64'h13198a2e03707344;
            4'd2:    return 64'ha4093822299f31d0;
            4'd3:    return 64'h082efa98ec4e6c89;
            4'd4:    return 64'h452821e638d01377;
            4'd5:    return 64'hbe5466cf34e90c6c;
            4'd6:    return 64'h7ef84f78fd955cb1;
            4'd7:    return 64'h85840851f1ac43aa;
            4'd8:    return 64'hc882d32f25323c54;
            4'd9:    return 64'h64a51195e0e3610d;
            4'd10:   return 64'hd3b5a399ca0c2399;
            4'd11:   return 64'hc0ac29b7c97c50dd;
            default: return 64'h0;
        endcase
    endfunction

    // Reduced-round variants skip the inner constants: the backward half is
    // shifted so that its last step always lands on RC11.
    function automatic logic [63:0] rc_sel(input logic [3:0] r, input logic e);
        logic [3:0] i;
        if (r > C_LAST) begin
            return 64'h0;
        end
        i = (r <= C_NH) ? r : r + C_OFS;
        if (!e) begin
            i = 4'd11 - i;
        end
        return rc_const(i);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rnd_q   <= 4'd0;
            sub_q   <= 4'd0;
            enc_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            sub_q   <= sub_d;
            enc_q   <= enc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        sub_d   = sub_q;
        enc_d   = enc_q;
        if (clr_i) begin
            state_d = S_IDLE;
            rnd_d   = 4'd0;
            sub_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        enc_d   = enc_i;
                        rnd_d   = 4'd0;
                        sub_d   = 4'd0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (sub_q == C_SUB_LAST) begin
                        sub_d = 4'd0;
                        if (rnd_q == C_LAST) begin
                            rnd_d   = 4'd0;
                            state_d = S_DONE;
                        end else begin
                            rnd_d = rnd_q + 4'd1;
                        end
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    logic w_enc_eff;

    // Outside RUN the constant lookup is pinned to the encrypt map so the
    // idle values do not depend on the direction of the previous run.
    always_comb begin
        busy_o    = (state_q == S_RUN);
        done_o    = (state_q == S_DONE);
        load_o    = busy_o && (rnd_q == 4'd0) && (sub_q == 4'd0);
        step_o    = busy_o && (sub_q == C_SUB_LAST);
        mid_o     = step_o && (rnd_q == C_NH);
        fwd_o     = busy_o && (rnd_q <= C_NH);
        inv_o     = busy_o && (rnd_q > C_NH);
        rnd_o     = rnd_q;
        sub_o     = sub_q;
        w_enc_eff = busy_o ? enc_q : 1'b1;
        rc_o      = rc_sel(rnd_q, w_enc_eff) ^ k_i;
        rc2_o     = rc_sel(rnd_q + 4'd1, w_enc_eff) ^ k_i;
    end

endmodule

`default_nettype wire

// File: tb/tb_prince_round_ctrl_param.sv
//==============================================================================
// Module   : tb_prince_round_ctrl_param
// Brief    : Directed self-checking bench for prince_round_ctrl_param.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_prince_round_ctrl_param;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clr;
    logic        enc;
    logic [63:0] k;

    // Instance 0: NR_HALF=5/LAT=1, 1: NR_HALF=2/LAT=1, 2: NR_HALF=5/LAT=3
    logic        busy [3];
    logic        done [3];
    logic        load [3];
    logic        step [3];
    logic        mid  [3];
    logic        fwd  [3];
    logic        inv  [3];
    logic [3:0]  rnd  [3];
    logic [3:0]  sub  [3];
    logic [63:0] rc   [3];
    logic [63:0] rc2  [3];

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] rc_tab [12] = '{
        64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
        64'h082efa98ec4e6c89, 64'h452821e638d01377, 64'hbe5466cf34e90c6c,
        64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
        64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd
    };

    logic [63:0] t3_exp [6] = '{
        64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
        64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd
    };

    prince_round_ctrl_param #(.NR_HALF(5), .SBOX_LAT(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clr_i(clr), .enc_i(enc), .k_i(k),
        .busy_o(busy[0]), .done_o(done[0]), .load_o(load[0]), .step_o(step[0]),
        .mid_o(mid[0]), .rnd_o(rnd[0]), .sub_o(sub[0]), .fwd_o(fwd[0]),
        .inv_o(inv[0]), .rc_o(rc[0]), .rc2_o(rc2[0])
    );

    prince_round_ctrl_param #(.NR_HALF(2), .SBOX_LAT(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clr_i(clr), .enc_i(enc), .k_i(k),
        .busy_o(busy[1]), .done_o(done[1]), .load_o(load[1]), .step_o(step[1]),
        .mid_o(mid[1]), .rnd_o(rnd[1]), .sub_o(sub[1]), .fwd_o(fwd[1]),
        .inv_o(inv[1]), .rc_o(rc[1]), .rc2_o(rc2[1])
    );

    prince_round_ctrl_param #(.NR_HALF(5), .SBOX_LAT(3)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clr_i(clr), .enc_i(enc), .k_i(k),
        .busy_o(busy[2]), .done_o(done[2]), .load_o(load[2]), .step_o(step[2]),
        .mid_o(mid[2]), .rnd_o(rnd[2]), .sub_o(sub[2]), .fwd_o(fwd[2]),
        .inv_o(inv[2]), .rc_o(rc[2]), .rc2_o(rc2[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic abort_all();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int          r;
        int          s;
        int          ndone;
        int          nsteps;
        int          dcyc;
        logic [63:0] e2;

        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        enc   = 1'b1;
        k     = 64'h0123456789abcdef;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst.busy", busy[0], 1'b0);
        chk1("rst.done", done[0], 1'b0);
        chk1("rst.load", load[0], 1'b0);
        chk1("rst.step", step[0], 1'b0);
        chk1("rst.mid",  mid[0],  1'b0);
        chk1("rst.fwd",  fwd[0],  1'b0);
        chk1("rst.inv",  inv[0],  1'b0);
        chk("rst.rnd", 64'(rnd[0]), 64'd0);
        chk("rst.sub", 64'(sub[2]), 64'd0);
        chk("rst.rc",  rc[0],  k);
        chk("rst.rc2", rc2[0], rc_tab[1] ^ k);
        #2 rst_n = 1'b1;
        tick();

        // Test 1: full encrypt, enc toggled mid-run must not matter
        k     = 64'h0;
        enc   = 1'b1;
        start = 1'b1;
        chk1("t1.c0.busy", busy[0], 1'b0);
        tick();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            r  = c - 1;
            e2 = (r == 11) ? 64'h0 : rc_tab[(r + 1) % 12];
            chk1("t1.busy", busy[0], 1'b1);
            chk1("t1.done", done[0], 1'b0);
            chk1("t1.load", load[0], c == 1);
            chk1("t1.step", step[0], 1'b1);
            chk1("t1.mid",  mid[0],  r == 5);
            chk1("t1.fwd",  fwd[0],  r <= 5);
            chk1("t1.inv",  inv[0],  r > 5);
            chk("t1.rnd", 64'(rnd[0]), 64'(r));
            chk("t1.sub", 64'(sub[0]), 64'd0);
            chk("t1.rc",  rc[0],  rc_tab[r]);
            chk("t1.rc2", rc2[0], e2);
            if (c == 3) enc = 1'b0;
            tick();
        end
        chk1("t1.c13.done", done[0], 1'b1);
        chk1("t1.c13.busy", busy[0], 1'b0);
        tick();
        chk1("t1.c14.done", done[0], 1'b0);
        abort_all();

        // Test 2: decrypt with all-ones key
        k     = 64'hffffffffffffffff;
        enc   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2.r0.rc",  rc[0],  64'h3f53d6483683af22);
        tick();
        chk("t2.r1.rc",  rc[0],  64'h2c4a5c6635f3dc66);
        repeat (10) tick();
        chk("t2.r11.rnd", 64'(rnd[0]), 64'd11);
        chk("t2.r11.rc",  rc[0],  64'hffffffffffffffff);
        chk("t2.r11.rc2", rc2[0], 64'hffffffffffffffff);
        tick();
        chk1("t2.done", done[0], 1'b1);
        chk("t2.done.rc",  rc[0],  64'hffffffffffffffff);
        tick();
        chk("t2.idle.rc2", rc2[0], 64'hece675d1fc8f8cbb);
        abort_all();

        // Test 3: reduced rounds NR_HALF=2
        k     = 64'h0;
        enc   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            r = c - 1;
            chk1("t3.busy", busy[1], 1'b1);
            chk1("t3.inv",  inv[1],  r >= 3);
            chk1("t3.mid",  mid[1],  r == 2);
            chk("t3.rnd", 64'(rnd[1]), 64'(r));
            chk("t3.rc",  rc[1], t3_exp[r]);
            if (r == 2) chk("t3.rc2", rc2[1], 64'h64a51195e0e3610d);
            tick();
        end
        chk1("t3.c7.done", done[1], 1'b1);
        abort_all();

        // Test 4: three cycles per round step
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            r = (c - 1) / 3;
            s = (c - 1) % 3;
            chk1("t4.busy", busy[2], 1'b1);
            chk1("t4.done", done[2], 1'b0);
            chk1("t4.load", load[2], c == 1);
            chk1("t4.step", step[2], s == 2);
            chk1("t4.mid",  mid[2],  (s == 2) && (r == 5));
            chk("t4.rnd", 64'(rnd[2]), 64'(r));
            chk("t4.sub", 64'(sub[2]), 64'(s));
            tick();
        end
        chk1("t4.c37.done", done[2], 1'b1);
        chk1("t4.c37.busy", busy[2], 1'b0);
        abort_all();

        // Test 5a: clr at rnd 4
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("t5.pre_clr.rnd", 64'(rnd[0]), 64'd4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk1("t5.clr.busy", busy[0], 1'b0);
        chk1("t5.clr.done", done[0], 1'b0);
        chk("t5.clr.rnd", 64'(rnd[0]), 64'd0);
        ndone = 0;
        repeat (15) begin
            if (done[0]) ndone++;
            tick();
        end
        chk("t5.clr.nodone", 64'(ndone), 64'd0);

        // Test 5b: full rerun with an ignored start during RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        nsteps = 0;
        ndone  = 0;
        dcyc   = 0;
        for (int c = 1; c <= 16; c++) begin
            if (step[0]) nsteps++;
            if (done[0]) begin
                ndone++;
                dcyc = c;
            end
            start = (c == 5);
            tick();
        end
        start = 1'b0;
        chk("t5.rerun.steps", 64'(nsteps), 64'd12);
        chk("t5.rerun.ndone", 64'(ndone),  64'd1);
        chk("t5.rerun.dcyc",  64'(dcyc),   64'd13);

        // Test 5c: asynchronous reset at rnd 7
        k     = 64'hdeadbeef00c0ffee;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("t5.pre_rst.rnd", 64'(rnd[0]), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        chk1("t5.rst.busy", busy[0], 1'b0);
        chk1("t5.rst.step", step[0], 1'b0);
        chk("t5.rst.rnd", 64'(rnd[0]), 64'd0);
        chk("t5.rst.rc",  rc[0],  k);
        chk("t5.rst.rc2", rc2[0], rc_tab[1] ^ k);
        #2 rst_n = 1'b1;
        tick();
        ndone = 0;
        repeat (15) begin
            if (done[0]) ndone++;
            tick();
        end
        chk("t5.rst.nodone", 64'(ndone), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prince_round_ctrl_param.md
Name: prince_round_ctrl_param

Overview:
Parametrised round controller for masked PRINCE cores with a start/busy/done handshake. Supports reduced-round variants and a configurable number of cycles per round, for multi-cycle masked S-box pipelines. Drives round index, phase flags, per-round update strobes, and current/next round-constant-xor-key to the datapath. Sits between the top-level wrapper and the masked round datapath.

Parameters:
NR_HALF, 5, forward rounds per half (1..5); total round steps T = 2*NR_HALF+2.
SBOX_LAT, 1, cycles per round step (1..15), matching the datapath S-box pipeline depth.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low.
start  in  1  begin operation; honoured only in IDLE.
clr  in  1  synchronous abort; forces IDLE next cycle, done not raised.
enc  in  1  1 = encrypt, 0 = decrypt; sampled with start.
k  in  64  k1 key word; held stable by the user for the whole run.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse in DONE.
load  out  1  high in the first RUN cycle (datapath loads plaintext/whitening).
step  out  1  high in the last cycle of each round step (datapath register update).
mid  out  1  step && rnd == NR_HALF (datapath applies middle S / M' / S^-1 on this update).
rnd  out  4  current round step index 0..T-1.
sub  out  4  cycle within the current step, 0..SBOX_LAT-1.
fwd  out  1  busy && rnd <= NR_HALF.
inv  out  1  busy && rnd > NR_HALF.
rc  out  64  RC[idx(rnd)] ^ k.
rc2  out  64  RC[idx(rnd+1)] ^ k; equals k when rnd == T-1.

Behaviour:
- Constant table RC0..RC11 is the standard PRINCE set: RC0=0, RC1=13198a2e03707344, RC2=a409382229 9f31d0 (a4093822299f31d0), RC3=082efa98ec4e6c89, RC4=452821e638d01377, RC5=be5466cf34e90c6c, RC6=7ef84f78fd955cb1, RC7=85840851f1ac43aa, RC8=c882d32f25323c54, RC9=64a51195e0e3610d, RC10=d3b5a399ca0c2399, RC11=c0ac29b7c97c50dd.
- Index map (encrypt): idx(r) = r for r <= NR_HALF; idx(r) = 11-(T-1-r) otherwise. Decrypt uses 11-idx(r), relying on alpha symmetry. Indices outside 0..T-1 map to constant 0.
- The state register (IDLE, RUN, DONE), rnd, sub and the latched enc_q are all registered. Reset values: IDLE, rnd=0, sub=0, enc_q=1. All 1-bit outputs are 0 in reset and IDLE. rc=k and rc2=RC1^k in reset and IDLE.
- IDLE: when start=1, enc_q<=enc, rnd<=0, sub<=0, go to RUN.
- RUN: each cycle sub increments. When sub==SBOX_LAT-1: step=1, sub<=0, rnd<=rnd+1. If rnd==T-1 at that point, go to DONE and reset rnd to 0.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in RUN and DONE.
- Latency: start sampled in cycle 0; load in cycle 1; done in cycle T*SBOX_LAT+1. Earliest restart is one cycle after done.
- clr has priority over every transition except reset. clr in any state: IDLE next cycle, rnd/sub cleared, no done.
- Asynchronous rst mid-run: all registers return to reset values immediately; no done is generated.
- enc changes during RUN have no effect, because enc_q is used.
- rnd never exceeds T-1, and sub never exceeds SBOX_LAT-1, so no wrap-around beyond T-1.
- SBOX_LAT=1: step is high in every RUN cycle and sub stays 0.

Test Plan:
1. NR_HALF=5, SBOX_LAT=1, enc=1, k=0, start pulse at cycle 0 -> load at cycle 1, busy for cycles 1..12, done only at cycle 13. In cycle 2 rnd=1 with rc=13198a2e03707344. In cycle 12 rnd=11 with rc=c0ac29b7c97c50dd and rc2=0. mid at rnd=5.
2. Same configuration, enc=0, k=ffffffffffffffff -> at rnd=0 rc=3f53d6483683af22 (RC11^k); at rnd=11 rc=ffffffffffffffff.
3. NR_HALF=2, SBOX_LAT=1, enc=1, k=0 -> T=6; rc sequence over rnd 0..5 is RC0, RC1, RC2, RC9, RC10, RC11 (rnd=3 gives 64a51195e0e3610d); done in cycle 7; inv high for rnd 3..5.
4. NR_HALF=5, SBOX_LAT=3 -> sub cycles 0,1,2 and step high only when sub=2; done in cycle 37; rnd held constant for 3 cycles each.
5. Abort and reset: clr at rnd=4 -> IDLE next cycle, done never asserted, next start runs the full 12 steps. rst low at rnd=7 -> outputs reset immediately. A start during RUN is ignored and done count stays at 1.
